// File: rtl/uart_tx.sv
// uart_tx: 8N1 (or 8N2) UART transmitter with a single-byte holding
// register. It accepts a byte while idle, serialises it LSB first behind a
// start bit and appends STOP_BITS stop bits. The line, ready and done
// outputs all come straight from flops.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       uart_txd
);

    // One counter serves every state. It is sized for the longest interval,
    // which is the whole stop period.
    localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    localparam int CNT_W     = $clog2(STOP_CLKS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;

    // State, counters and registered outputs. Reset returns the line high
    // immediately, even if a frame is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. The outputs are derived from the next state, so
    // the flopped line already shows the new bit in the cycle that follows
    // each transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            IDLE: begin
                // Requests are honoured only here. The byte is captured once
                // and is unaffected by later changes on tx_data.
                if (tx_enable) begin
                    state_d = START;
                    shift_d = tx_data;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        txd_d = 1'b1;
        if (state_d == START) begin
            txd_d = 1'b0;
        end else if (state_d == DATA) begin
            txd_d = shift_d[0];
        end
        rdy_d  = (state_d == IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    assign uart_txd = txd_q;
    assign tx_ready = rdy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Instance A uses 1 stop bit and
// instance B uses 2 stop bits, both with 4 clocks per bit. Expected frames
// are hand-built as {stop, data, start} patterns.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic       rdy_a, done_a, txd_a;
    logic       rdy_b, done_b, txd_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t1, t2, t3, t4;

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_enable(en_a),
        .tx_ready(rdy_a), .tx_done(done_a), .uart_txd(txd_a)
    );

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_enable(en_b),
        .tx_ready(rdy_b), .tx_done(done_b), .uart_txd(txd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after the accept edge. It walks the 40 frame cycles
    // of instance A and then checks the idle/done cycle.
    // mode 1: tx_data is set to 0 mid-frame.
    // mode 2: a 0xFF request is pulsed during data bit 3.
    task automatic frame_a(input string name, input logic [9:0] pat, input int mode,
                           output int t0);
        t0 = cyc;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) tick();
            chk($sformatf("%s txd c%0d", name, j), txd_a, pat[j/4]);
            chk($sformatf("%s rdy c%0d", name, j), rdy_a, 0);
            chk($sformatf("%s done c%0d", name, j), done_a, 0);
            if (mode == 1 && j == 10) tx_data = 8'h00;
            if (mode == 2 && j == 16) begin
                tx_data = 8'hFF;
                en_a    = 1'b1;
            end
            if (mode == 2 && j == 17) en_a = 1'b0;
        end
        tick();
        chk($sformatf("%s done pulse", name), done_a, 1);
        chk($sformatf("%s rdy back", name), rdy_a, 1);
        chk($sformatf("%s txd idle", name), txd_a, 1);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst txd", txd_a, 1);
        chk("rst rdy", rdy_a, 1);
        chk("rst done", done_a, 0);
        chk("rst rdy b", rdy_b, 1);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle txd", txd_a, 1);
            chk("idle rdy", rdy_a, 1);
            chk("idle done", done_a, 0);
        end

        // Single-cycle request: 0x53 -> 0,1,1,0,0,1,0,1,0,1.
        tx_data = 8'h53;
        en_a    = 1'b1;
        tick();
        en_a = 1'b0;
        frame_a("f53", 10'b1010100110, 0, t1);

        // Held request: 0xA5 sent twice back to back. tx_data is zeroed
        // during the second frame.
        tx_data = 8'hA5;
        en_a    = 1'b1;
        tick();
        frame_a("fA5a", 10'b1101001010, 0, t1);
        tick();
        en_a = 1'b0;
        frame_a("fA5b", 10'b1101001010, 1, t2);
        chk("start gap", t2 - t1, 41);
        tick();
        chk("no 3rd frame txd", txd_a, 1);
        chk("no 3rd frame rdy", rdy_a, 1);

        // A request that arrives mid-frame is ignored.
        tx_data = 8'h3C;
        en_a    = 1'b1;
        tick();
        en_a = 1'b0;
        frame_a("f3C", 10'b1001111000, 2, t3);
        tick();
        chk("ignored txd", txd_a, 1);
        chk("ignored rdy", rdy_a, 1);
        chk("ignored done", done_a, 0);

        // Reset asserted during data bit 5 of 0xC3, where the line is low.
        tx_data = 8'hC3;
        en_a    = 1'b1;
        tick();
        en_a = 1'b0;
        for (int j = 1; j <= 26; j++) tick();
        chk("pre-rst bit5", txd_a, 0);
        chk("pre-rst rdy", rdy_a, 0);
        #1 rst = 1'b0;
        #1;
        chk("async rst txd", txd_a, 1);
        chk("async rst rdy", rdy_a, 1);
        chk("async rst done", done_a, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post-rst txd", txd_a, 1);
        tx_data = 8'h0F;
        en_a    = 1'b1;
        tick();
        en_a = 1'b0;
        frame_a("f0F", 10'b1000011110, 0, t4);

        // Two stop bits on instance B with 0x00: 36 low cycles, then 8 high.
        tx_data = 8'h00;
        en_b    = 1'b1;
        tick();
        en_b = 1'b0;
        for (int j = 0; j < 44; j++) begin
            if (j > 0) tick();
            chk($sformatf("b txd c%0d", j), txd_b, (j < 36) ? 0 : 1);
            chk($sformatf("b rdy c%0d", j), rdy_b, 0);
        end
        tick();
        chk("b rdy back", rdy_b, 1);
        chk("b done pulse", done_b, 1);
        tick();
        chk("b done drop", done_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
